// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter; one whole transaction per grant.
// Optional round-robin between IFU and LSU when AXI_ARB_RR_EN is defined; fixed priority otherwise.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // IFU read
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    // LSU read
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    // LSU write
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [1:0]        lsu_bresp,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,
    // Slave
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q,  w_done_d;

    logic wr_req;
    logic lsu_req;
    logic ifu_wins;

    // A write is only eligible once both address and data are offered.
    assign wr_req  = lsu_awvalid && lsu_wvalid;
    assign lsu_req = wr_req || lsu_arvalid;

`ifdef AXI_ARB_RR_EN
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        last_lsu_d = last_lsu_q;
        if (state_q == IDLE && state_d != IDLE) begin
            last_lsu_d = (state_d != IFU_RD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end

    assign ifu_wins = ifu_arvalid && (!lsu_req || last_lsu_q);
`else
    assign ifu_wins = ifu_arvalid && !lsu_req;
`endif

    always_comb begin
        logic ar_hs;
        logic r_hs;
        logic aw_hs;
        logic w_hs;
        logic b_hs;

        // NOTE: every output and next-state value gets a default first so no path leaves a latch.
        state_d     = state_q;
        ar_done_d   = ar_done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;

        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;

        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_wins) begin
                    state_d = IFU_RD;
                end else if (wr_req) begin
                    state_d = LSU_WR;
                end else if (lsu_arvalid) begin
                    state_d = LSU_RD;
                end
            end

            IFU_RD: begin
                if (!ar_done_q) begin
                    s_araddr    = ifu_araddr;
                    s_arvalid   = ifu_arvalid;
                    ifu_arready = s_arready;
                    ar_hs       = ifu_arvalid && s_arready;
                end
                ifu_rdata  = s_rdata;
                ifu_rresp  = s_rresp;
                ifu_rvalid = s_rvalid;
                s_rready   = ifu_rready;
                r_hs       = s_rvalid && ifu_rready;
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                end
                if (r_hs) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end

            LSU_RD: begin
                if (!ar_done_q) begin
                    s_araddr    = lsu_araddr;
                    s_arvalid   = lsu_arvalid;
                    lsu_arready = s_arready;
                    ar_hs       = lsu_arvalid && s_arready;
                end
                lsu_rdata  = s_rdata;
                lsu_rresp  = s_rresp;
                lsu_rvalid = s_rvalid;
                s_rready   = lsu_rready;
                r_hs       = s_rvalid && lsu_rready;
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                end
                if (r_hs) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end

            LSU_WR: begin
                // AW and W retire independently; each flag blocks a second beat on its channel.
                if (!aw_done_q) begin
                    s_awaddr    = lsu_awaddr;
                    s_awvalid   = lsu_awvalid;
                    lsu_awready = s_awready;
                    aw_hs       = lsu_awvalid && s_awready;
                end
                if (!w_done_q) begin
                    s_wdata    = lsu_wdata;
                    s_wstrb    = lsu_wstrb;
                    s_wvalid   = lsu_wvalid;
                    lsu_wready = s_wready;
                    w_hs       = lsu_wvalid && s_wready;
                end
                lsu_bresp  = s_bresp;
                lsu_bvalid = s_bvalid;
                s_bready   = lsu_bready;
                b_hs       = s_bvalid && lsu_bready;
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if (b_hs) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed scoreboard bench for axi_lite_arbiter with a behavioural single-outstanding SRAM slave.
// Honours AXI_ARB_RR_EN when choosing the expected grant order.
module tb_axi_lite_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid, ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid, ifu_rready;
    logic [AW-1:0] lsu_araddr;
    logic          lsu_arvalid, lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid, lsu_rready;
    logic [AW-1:0] lsu_awaddr;
    logic          lsu_awvalid, lsu_awready;
    logic [DW-1:0] lsu_wdata;
    logic [SW-1:0] lsu_wstrb;
    logic          lsu_wvalid, lsu_wready;
    logic [1:0]    lsu_bresp;
    logic          lsu_bvalid, lsu_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid, s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid, s_rready;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid, s_awready;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_wvalid, s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid, s_bready;

    axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_0F0F);
    endfunction

    // Behavioural slave: one read outstanding, B issued once both AW and W arrived.
    logic          ar_ok, r_ok, w_ok;
    logic [1:0]    slave_rresp;
    logic          rd_pend, aw_got, w_got, b_pend;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    assign s_arready = ar_ok;
    assign s_rvalid  = rd_pend && r_ok;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_awready = !b_pend;
    assign s_wready  = !b_pend && w_ok;
    assign s_bvalid  = b_pend;
    assign s_bresp   = 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_pend  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            if (s_arvalid && s_arready) begin
                rd_pend <= 1'b1;
                rdata_q <= data_of(s_araddr);
                rresp_q <= slave_rresp;
            end else if (s_rvalid && s_rready) begin
                rd_pend <= 1'b0;
            end
            if (s_awvalid && s_awready) aw_got <= 1'b1;
            if (s_wvalid && s_wready)   w_got  <= 1'b1;
            if (aw_got && w_got) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else if (s_bvalid && s_bready) begin
                b_pend <= 1'b0;
            end
        end
    end

    logic [11:0] all_ctl;
    assign all_ctl = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, ifu_arready,
                      ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};

    // Scoreboard: 0 = IFU read, 1 = LSU read, 2 = LSU write, in expected grant order.
    int            exp_order[$];
    logic [AW-1:0] exp_ar_ifu[$], exp_ar_lsu[$], exp_aw[$];
    logic [DW+SW-1:0] exp_w[$];
    logic [DW+1:0] exp_ifu_r[$], exp_lsu_r[$];
    logic [1:0]    exp_b[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_ar_cyc[2];
    int last_r_cyc[2];
    bit hold_ar = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit sb_empty();
        return exp_order.size() == 0 && exp_ar_ifu.size() == 0 && exp_ar_lsu.size() == 0 &&
               exp_aw.size() == 0 && exp_w.size() == 0 && exp_ifu_r.size() == 0 &&
               exp_lsu_r.size() == 0 && exp_b.size() == 0;
    endfunction

    // One clock: observe at negedge, let the edge happen, then retire accepted master valids.
    task automatic step();
        bit ifu_hs, lsu_hs, aw_hs, w_hs;
        int m;
        @(negedge clk);
        check("exclusive", (ifu_arready | ifu_rvalid) &&
              (lsu_arready | lsu_rvalid | lsu_awready | lsu_wready | lsu_bvalid), 0);
        ifu_hs = ifu_arvalid && ifu_arready;
        lsu_hs = lsu_arvalid && lsu_arready;
        aw_hs  = lsu_awvalid && lsu_awready;
        w_hs   = lsu_wvalid && lsu_wready;
        if (s_arvalid && s_arready) begin
            m = lsu_arready ? 1 : (ifu_arready ? 0 : 3);
            check("ar_expected", exp_order.size() != 0, 1);
            if (exp_order.size() != 0) check("ar_order", m, exp_order.pop_front());
            if (m == 0) begin
                check("ifu_ar_expected", exp_ar_ifu.size() != 0, 1);
                if (exp_ar_ifu.size() != 0) check("ifu_araddr", s_araddr, exp_ar_ifu.pop_front());
                last_ar_cyc[0] = cyc;
            end else if (m == 1) begin
                check("lsu_ar_expected", exp_ar_lsu.size() != 0, 1);
                if (exp_ar_lsu.size() != 0) check("lsu_araddr", s_araddr, exp_ar_lsu.pop_front());
                last_ar_cyc[1] = cyc;
            end
        end
        if (s_awvalid && s_awready) begin
            check("aw_expected", exp_aw.size() != 0, 1);
            if (exp_aw.size() != 0) begin
                check("aw_order", 2, exp_order.size() != 0 ? exp_order.pop_front() : -1);
                check("s_awaddr", s_awaddr, exp_aw.pop_front());
            end
        end
        if (s_wvalid && s_wready) begin
            check("w_expected", exp_w.size() != 0, 1);
            if (exp_w.size() != 0) check("s_wdata_strb", {s_wdata, s_wstrb}, exp_w.pop_front());
        end
        if (ifu_rvalid && ifu_rready) begin
            check("ifu_r_expected", exp_ifu_r.size() != 0, 1);
            if (exp_ifu_r.size() != 0) check("ifu_rdata_resp", {ifu_rdata, ifu_rresp}, exp_ifu_r.pop_front());
            last_r_cyc[0] = cyc;
        end
        if (lsu_rvalid && lsu_rready) begin
            check("lsu_r_expected", exp_lsu_r.size() != 0, 1);
            if (exp_lsu_r.size() != 0) check("lsu_rdata_resp", {lsu_rdata, lsu_rresp}, exp_lsu_r.pop_front());
            last_r_cyc[1] = cyc;
        end
        if (lsu_bvalid && lsu_bready) begin
            check("b_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) check("lsu_bresp", lsu_bresp, exp_b.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ifu_hs && !hold_ar) ifu_arvalid = 1'b0;
        if (lsu_hs) lsu_arvalid = 1'b0;
        if (aw_hs)  lsu_awvalid = 1'b0;
        if (w_hs)   lsu_wvalid  = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (!sb_empty() && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", sb_empty(), 1);
    endtask

    task automatic ifu_read(input logic [AW-1:0] a, input logic [1:0] resp);
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        exp_ar_ifu.push_back(a);
        exp_ifu_r.push_back({data_of(a), resp});
    endtask

    task automatic lsu_read(input logic [AW-1:0] a, input logic [1:0] resp);
        lsu_araddr  = a;
        lsu_arvalid = 1'b1;
        exp_ar_lsu.push_back(a);
        exp_lsu_r.push_back({data_of(a), resp});
    endtask

    task automatic lsu_write_addr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        lsu_awaddr  = a;
        lsu_awvalid = 1'b1;
        lsu_wdata   = d;
        lsu_wstrb   = s;
        exp_aw.push_back(a);
        exp_w.push_back({d, s});
        exp_b.push_back(2'b00);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
        lsu_bready = 1'b1;
        ar_ok = 1'b1; r_ok = 1'b1; w_ok = 1'b1; slave_rresp = 2'b00;
        last_ar_cyc = '{0, 0};
        last_r_cyc  = '{0, 0};

        #12;
        check("reset_outputs", all_ctl, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_outputs", all_ctl, 0);

        // IFU only, valid held through the whole transaction: exactly one AR reaches the slave.
        hold_ar = 1'b1;
        ifu_read(32'h8000_0000, 2'b00);
        exp_order.push_back(0);
        #1;
        check("idle_no_ready", {s_arvalid, ifu_arready}, 0);
        step();
        check("grant_latency", {s_arvalid, ifu_arready}, 2'b11);
        n = 0;
        while (exp_ifu_r.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("ifu_r_seen", exp_ifu_r.size(), 0);
        ifu_arvalid = 1'b0;
        hold_ar = 1'b0;
        #1;
        check("back_to_idle", all_ctl, 0);
        step();
        step();
        check("ifu_single_ar", sb_empty(), 1);

        // Simultaneous reads after an LSU-only read (pointer left on LSU).
        lsu_read(32'h8000_0100, 2'b00);
        exp_order.push_back(1);
        run_until_done(20);
        ifu_read(32'h8000_0204, 2'b00);
        lsu_read(32'h8000_0308, 2'b00);
`ifdef AXI_ARB_RR_EN
        exp_order.push_back(0);
        exp_order.push_back(1);
        run_until_done(30);
        check("regrant_via_idle", last_ar_cyc[1] - last_r_cyc[0], 2);
`else
        exp_order.push_back(1);
        exp_order.push_back(0);
        run_until_done(30);
        check("regrant_via_idle", last_ar_cyc[0] - last_r_cyc[1], 2);
`endif

        // LSU write, W offered two cycles after AW, slave holds W off after AW retires.
        w_ok = 1'b0;
        lsu_write_addr(32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
        exp_order.push_back(2);
        #1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("aw_alone_ineligible", {s_awvalid, lsu_awready, s_wvalid}, 0);
        end
        lsu_wvalid = 1'b1;
        step();
        check("wr_granted", {s_awvalid, s_wvalid}, 2'b11);
        step();
        check("aw_once", {s_awvalid, s_wvalid}, 2'b01);
        w_ok = 1'b1;
        run_until_done(20);

        // Three-way contention; an IFU read first leaves the pointer on IFU.
        ifu_read(32'h8000_0010, 2'b00);
        exp_order.push_back(0);
        run_until_done(20);
        lsu_write_addr(32'h8000_2000, 32'h1234_5678, 4'b1111);
        lsu_wvalid = 1'b1;
        lsu_read(32'h8000_3000, 2'b00);
        ifu_read(32'h8000_4000, 2'b00);
`ifdef AXI_ARB_RR_EN
        exp_order.push_back(2);
        exp_order.push_back(0);
        exp_order.push_back(1);
`else
        exp_order.push_back(2);
        exp_order.push_back(1);
        exp_order.push_back(0);
`endif
        run_until_done(60);

        // Error response passes through untouched to the LSU only.
        slave_rresp = 2'b10;
        lsu_read(32'h8000_5000, 2'b10);
        exp_order.push_back(1);
        run_until_done(20);
        slave_rresp = 2'b00;

        // Reset while LSU_RD still presents its AR.
        ar_ok = 1'b0;
        lsu_araddr  = 32'h8000_6000;
        lsu_arvalid = 1'b1;
        step();
        check("rd_before_rst", {s_arvalid, lsu_arready}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_drop", all_ctl, 0);
        lsu_arvalid = 1'b0;
        ar_ok = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_idle", all_ctl, 0);
        ifu_read(32'h8000_7000, 2'b00);
        exp_order.push_back(0);
        run_until_done(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter that shares the data SRAM slave between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the core's IFU/LSU bus ports and the SRAM slave.
- Grants one whole transaction at a time and forwards channels combinationally while a grant is held.
- Response routing is decided by a registered grant.

Parameters:
- ADDR_W, 32, AXI address width (matches `AXI_ADDR_BUS).
- DATA_W, 32, AXI data width (matches `AXI_DATA_BUS).
- STRB_W, 4, write strobe width, DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ifu_araddr/ifu_arvalid/ifu_arready  in/in/out  ADDR_W/1/1  IFU read address channel.
- ifu_rdata/ifu_rresp/ifu_rvalid/ifu_rready  out/out/out/in  DATA_W/2/1/1  IFU read data channel.
- lsu_araddr/lsu_arvalid/lsu_arready  in/in/out  ADDR_W/1/1  LSU read address channel.
- lsu_rdata/lsu_rresp/lsu_rvalid/lsu_rready  out/out/out/in  DATA_W/2/1/1  LSU read data channel.
- lsu_awaddr/lsu_awvalid/lsu_awready  in/in/out  ADDR_W/1/1  LSU write address channel.
- lsu_wdata/lsu_wstrb/lsu_wvalid/lsu_wready  in/in/in/out  DATA_W/STRB_W/1/1  LSU write data channel.
- lsu_bresp/lsu_bvalid/lsu_bready  out/out/in  2/1/1  LSU write response channel.
- s_araddr/s_arvalid/s_arready  out/out/in  ADDR_W/1/1  slave read address channel.
- s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  DATA_W/2/1/1  slave read data channel.
- s_awaddr/s_awvalid/s_awready  out/out/in  ADDR_W/1/1  slave write address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  DATA_W/STRB_W/1/1  slave write data channel.
- s_bresp/s_bvalid/s_bready  in/in/out  2/1/1  slave write response channel.

Behaviour:
- Reset is asynchronous: on rst=1, state goes to IDLE and all flags and the round-robin pointer clear.
- Every valid and ready output is 0 while in reset and in IDLE.
- Data, addr and resp outputs are don't-care when the matching valid is 0; drive 0 when not granted.
- States: IDLE, IFU_RD, LSU_RD, LSU_WR (registered).
- IDLE arbitration uses fixed priority: LSU write (lsu_awvalid && lsu_wvalid both high) > LSU read (lsu_arvalid) > IFU read (ifu_arvalid).
- An LSU write with only one of awvalid/wvalid high is not eligible.
- A request sampled in IDLE at edge N gives the grant state from cycle N+1; slave valids are first asserted in cycle N+1 (1-cycle arbitration latency). Masters get no ready in IDLE.
- IFU_RD / LSU_RD:
  - s_ar* is driven from the granted master while ar_done=0, and that master's arready = s_arready.
  - On the AR handshake, ar_done is set, so the slave sees exactly one AR.
  - s_r* is routed to the granted master; s_rready = granted master's rready.
  - On the R handshake, return to IDLE and clear ar_done.
- LSU_WR:
  - AW and W are forwarded independently, each guarded by its own flag (aw_done, w_done), and each is accepted exactly once.
  - AW and W may complete in the same or different cycles.
  - The B channel is routed to the LSU. On the B handshake, return to IDLE and clear both flags.
- The non-granted master always sees arready/awready/wready/rvalid/bvalid = 0.
- A master's valid may rise or fall freely while not granted; nothing is latched before grant.
- The same or another master may be granted on the cycle after return to IDLE; there is no back-to-back grant without passing through IDLE.
- rresp/bresp pass through unmodified, including error codes.
- Reset mid-transaction returns to IDLE immediately and drops slave valids. The slave must be reset on the same rst.
- No timeout: the arbiter waits indefinitely for slave responses.

Optional Feature:
- Macro AXI_ARB_RR_EN.
- Defined: a 1-bit last-granted pointer (reset = IFU) rotates priority between the IFU and LSU masters.
  - When both request in IDLE, the master not granted last wins.
  - Within LSU, write still beats read.
  - The pointer updates on entering a grant state.
- Undefined: fixed priority as above, and no pointer register exists.

Test Plan:
- IFU only: ifu_araddr=0x80000000 held valid, slave returns 0x00000413 -> exactly one s_arvalid handshake; ifu_rvalid=1 with ifu_rdata=0x00000413, ifu_rresp=0; state back to IDLE after the R handshake.
- Simultaneous IFU read and LSU read in IDLE (fixed priority) -> LSU granted first; IFU granted on the cycle after IDLE is re-entered. With AXI_ARB_RR_EN and pointer=LSU -> IFU granted first.
- LSU write: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=4'b0011, with W valid 2 cycles after AW -> one AW handshake and one W handshake; s_wstrb=4'b0011; lsu_bvalid forwarded; bresp=0.
- LSU write plus LSU read plus IFU read all valid at once -> order LSU write, LSU read, IFU read. Readies to losers stay 0 throughout.
- Slave returns rresp=2'b10 for an LSU read -> lsu_rresp=2'b10 and ifu_rvalid stays 0.
- rst asserted during LSU_RD before the R handshake -> all s_*valid and master readies drop to 0 in the same cycle (asynchronous); state is IDLE after release.
